// File: rtl/chaos_pkg.sv
// Shared types and constants for the chaos keystream extractor.
package chaos_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  localparam logic [7:0] EXP_NONFINITE = 8'hFF;
  localparam int         KEY_X1_LSB    = 0;
  localparam int         KEY_X2_LSB    = 5;
  localparam int         KEY_X3_LSB    = 10;

  // Inf and NaN share the all-ones exponent; either one poisons the sample.
  function automatic logic is_nonfinite(input float32_t f);
    return f.exp == EXP_NONFINITE;
  endfunction

endpackage

// File: rtl/chaos_key_fifo.sv
// First-word-fall-through byte FIFO. Occupancy is the difference of
// free-running write/read counts that carry one extra wrap bit, so full
// and empty never alias. A push into a full FIFO with no pop is dropped
// and reported on 'drop' for one cycle.
module chaos_key_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          drop
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_cnt, rd_cnt;
  logic        do_push, do_pop;

  assign level   = wr_cnt - rd_cnt;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A pop frees the slot a same-edge push needs, so full+pop still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  // Head is forced to zero when empty so the output is defined from reset.
  assign rd_data = empty ? 8'h00 : mem[rd_cnt[AW-1:0]];

  // Write/read counts; wrap is implicit in the modulo-2^(AW+1) arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + (AW+1)'(1);
      if (do_pop)  rd_cnt <= rd_cnt + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/chaos_keystream_extractor.sv
// Turns free-running chaos generator samples into key bytes: skips the
// transient warm-up, rejects Inf/NaN samples, folds mantissa bits of the
// three state variables into one byte, and queues the bytes for the cipher.
module chaos_keystream_extractor
  import chaos_pkg::*;
#(
  parameter int WARMUP     = 1000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic [31:0]                   x1_in,
  input  logic [31:0]                   x2_in,
  input  logic [31:0]                   x3_in,
  input  logic                          err_clr,
  output logic [7:0]                    key_byte,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          warm_done,
  output logic                          nonfinite_err,
  output logic                          overflow_err
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0]   WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam bit              NO_WARM   = (WARMUP == 0);

  logic          accept, nonfin, finite_ok, keep;
  logic [7:0]    k;
  logic [CW-1:0] warm_cnt;
  logic          s1_vld;
  logic [7:0]    s1_key;
  logic          fifo_empty, fifo_drop, fifo_full_unused;
  logic          unused_bits;

  assign accept    = enable & in_valid;
  assign nonfin    = is_nonfinite(float32_t'(x1_in)) |
                     is_nonfinite(float32_t'(x2_in)) |
                     is_nonfinite(float32_t'(x3_in));
  assign finite_ok = accept & ~nonfin;
  // With no warm-up configured, samples count from the very first edge.
  assign keep      = finite_ok & (warm_done | NO_WARM);
  assign k         = x1_in[KEY_X1_LSB +: 8] ^ x2_in[KEY_X2_LSB +: 8] ^ x3_in[KEY_X3_LSB +: 8];
  assign key_valid = ~fifo_empty;

  // Sign, upper mantissa and unfolded low bits do not feed the key.
  assign unused_bits = &{x1_in[31], x1_in[22:8], x2_in[31], x2_in[22:13],
                         x2_in[4:0], x3_in[31], x3_in[22:18], x3_in[9:0]};

  // Warm-up: count finite samples; the WARMUP-th one sets warm_done and is
  // still discarded because keep looks at the pre-edge warm_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt  <= '0;
      warm_done <= 1'b0;
    end else if (NO_WARM) begin
      warm_done <= 1'b1;
    end else if (finite_ok && !warm_done) begin
      warm_cnt <= warm_cnt + CW'(1);
      if (warm_cnt == WARM_LAST) warm_done <= 1'b1;
    end
  end

  // Single pipeline stage between extraction and the FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_key <= 8'h00;
    end else begin
      s1_vld <= keep;
      s1_key <= k;
    end
  end

  // Sticky error flags; a new event on the clearing edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonfinite_err <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (accept && nonfin) nonfinite_err <= 1'b1;
      else if (err_clr)     nonfinite_err <= 1'b0;
      if (fifo_drop)        overflow_err  <= 1'b1;
      else if (err_clr)     overflow_err  <= 1'b0;
    end
  end

  chaos_key_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_vld),
    .push_data (s1_key),
    .pop       (key_ready),
    .rd_data   (key_byte),
    .empty     (fifo_empty),
    .full      (fifo_full_unused),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

endmodule

// File: tb/tb_chaos_keystream_extractor.sv
// Directed bench for the keystream extractor with WARMUP=4, FIFO_DEPTH=4.
module tb_chaos_keystream_extractor;

  localparam int WARMUP = 4;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b1, in_valid = 1'b0, err_clr = 1'b0, key_ready = 1'b0;
  logic [31:0] x1_in = '0, x2_in = '0, x3_in = '0;
  logic [7:0]  key_byte;
  logic        key_valid, warm_done, nonfinite_err, overflow_err;
  logic [2:0]  fifo_level;
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;

  chaos_keystream_extractor #(.WARMUP(WARMUP), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .in_valid      (in_valid),
    .x1_in         (x1_in),
    .x2_in         (x2_in),
    .x3_in         (x3_in),
    .err_clr       (err_clr),
    .key_byte      (key_byte),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .fifo_level    (fifo_level),
    .warm_done     (warm_done),
    .nonfinite_err (nonfinite_err),
    .overflow_err  (overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feedf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid = 1'b1;
    x1_in = a; x2_in = b; x3_in = c;
    step();
    in_valid = 1'b0;
  endtask

  // x2=x3=0 and exponent 0, so the produced key equals the byte itself.
  task automatic feed(input logic [7:0] b);
    feedf({24'h0, b}, 32'h0, 32'h0);
  endtask

  initial begin
    logic [7:0] b;

    // Reset held with random inputs
    in_valid = 1'b1;
    repeat (3) begin
      x1_in = $urandom; x2_in = $urandom; x3_in = $urandom;
      step();
    end
    in_valid = 1'b0;
    chk("rst_key_valid", key_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_warm_done", warm_done, 0);
    chk("rst_nonfinite", nonfinite_err, 0);
    chk("rst_overflow", overflow_err, 0);
    rst_n = 1'b1;

    // Run through warm-up, then assert reset between edges
    for (int i = 0; i < 6; i++) feed(8'(8'h10 + i));
    chk("pre_async_warm", warm_done, 1);
    chk("pre_async_level", fifo_level, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_level", fifo_level, 0);
    chk("async_warm", warm_done, 0);
    chk("async_key_valid", key_valid, 0);
    step();
    rst_n = 1'b1;

    // Warm-up with a NaN sample that must not count
    feedf(32'h3F800000, 32'h40000000, 32'h40400000);
    feedf(32'hBF800000, 32'h00000000, 32'h3F000000);
    chk("warm_after2", warm_done, 0);
    feedf(32'h7FC00000, 32'h3F800000, 32'h3F800000);
    chk("nan_flag", nonfinite_err, 1);
    chk("nan_warm", warm_done, 0);
    feedf(32'h3E800000, 32'h00000001, 32'h80000000);
    chk("warm_after3", warm_done, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("nan_clr", nonfinite_err, 0);
    feedf(32'h00000001, 32'h00000000, 32'h00400000);
    chk("warm_after4", warm_done, 1);
    step(); step();
    chk("warm_no_bytes", fifo_level, 0);

    // Extraction: 0xCD ^ 0xB8 ^ 0x00 = 0x75, visible two edges after accept
    feedf(32'h3DCCCCCD, 32'h3C23D70A, 32'h00000000);
    chk("lat_edge_n", key_valid, 0);
    step();
    chk("lat_edge_n1", key_valid, 1);
    chk("key_0x75", key_byte, 8'h75);
    chk("level_1", fifo_level, 1);
    key_ready = 1'b1; step(); key_ready = 1'b0;
    chk("pop_empty", key_valid, 0);

    // Overflow: 6 bytes into depth 4 with no consumer
    for (int i = 0; i < 6; i++) begin
      feed(8'(8'h11 * (i + 1)));
      if (i == 4) begin
        chk("ovf_at_full", overflow_err, 0);
        chk("ovf_level4", fifo_level, 4);
      end
    end
    chk("ovf_5th_push", overflow_err, 1);
    step();
    chk("ovf_level_hold", fifo_level, 4);
    chk("ovf_head", key_byte, 8'h11);
    step();
    chk("ovf_head_stable", key_byte, 8'h11);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      chk("ovf_drain", key_byte, b);
      step();
    end
    key_ready = 1'b0;
    chk("ovf_drained", key_valid, 0);
    chk("ovf_sticky", overflow_err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("ovf_clr", overflow_err, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 5; i++) feed(8'(8'hA0 + i));
    chk("fp_level", fifo_level, 4);
    chk("fp_head", key_byte, 8'hA0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x1_in = {24'h0, 8'(8'hA5 + i)};
      chk("fp_stream", key_byte, 8'(8'hA0 + i));
      chk("fp_level_hold", fifo_level, 4);
      step();
    end
    in_valid = 1'b0;
    chk("fp_no_ovf", overflow_err, 0);
    for (int i = 0; i < 5; i++) begin
      chk("fp_tail", key_byte, 8'(8'hA4 + i));
      step();
    end
    key_ready = 1'b0;
    chk("fp_empty", key_valid, 0);
    chk("fp_no_ovf_end", overflow_err, 0);

    // enable=0 blocks acceptance
    enable = 1'b0; in_valid = 1'b1; x1_in = 32'h33;
    step(); step(); step();
    in_valid = 1'b0; enable = 1'b1;
    step();
    chk("disabled_level", fifo_level, 0);

    // Reset mid-stream, then warm-up repeats
    feed(8'hC1); feed(8'hC2); feed(8'hC3); step();
    chk("mid_level3", fifo_level, 3);
    chk("mid_warm", warm_done, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_warm", warm_done, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) feed(8'(8'h01 + i));
    chk("rewarm_done", warm_done, 1);
    step(); step();
    chk("rewarm_discard", fifo_level, 0);
    feed(8'h5A); step();
    chk("rewarm_valid", key_valid, 1);
    chk("rewarm_byte", key_byte, 8'h5A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/chaos_keystream_extractor.md
Name: chaos_keystream_extractor

Overview:
- Sits directly downstream of the three-variable chaos generator and consumes its x1/x2/x3 IEEE-754 single-precision outputs, one sample per clock.
- Discards a configurable transient warm-up period and rejects non-finite samples.
- Folds the mantissa bits of each valid sample into one key byte.
- Buffers the key bytes in a FIFO and presents them to the cipher stage over a valid/ready handshake.

Parameters:
- WARMUP, 1000: number of finite samples discarded after reset. 0 means no discard.
- FIFO_DEPTH, 16: key-byte FIFO depth. Power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  sample acceptance enable
- in_valid  in  1  x*_in carry a new generator sample this cycle
- x1_in  in  32  generator x1, IEEE-754 single
- x2_in  in  32  generator x2, IEEE-754 single
- x3_in  in  32  generator x3, IEEE-754 single
- err_clr  in  1  synchronous clear of the sticky error flags
- key_byte  out  8  head-of-FIFO key byte
- key_valid  out  1  key_byte valid
- key_ready  in  1  consumer accepts key_byte
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- warm_done  out  1  warm-up complete
- nonfinite_err  out  1  sticky: a sample with exponent 8'hFF was seen
- overflow_err  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset: asynchronous, active-low, applied immediately.
  - All outputs go to 0; FIFO empties; warm-up counter and pipeline register clear.
  - Applies equally mid-operation: any buffered bytes are lost.
- Acceptance: a sample is accepted on a rising edge with enable=1 and in_valid=1.
  - There is no backpressure toward the generator, because the generator free-runs.
- Non-finite check: an accepted sample is non-finite if any of x1/x2/x3 has bits[30:23]==8'hFF.
  - The sample is dropped and nonfinite_err is set.
  - It does not advance the warm-up counter.
- Warm-up:
  - Each accepted finite sample increments the counter until it reaches WARMUP; those samples are discarded.
  - warm_done rises on the edge that accepts the WARMUP-th finite sample, and that sample is itself discarded.
  - With WARMUP=0, warm_done=1 from the first edge after reset release.
  - warm_done stays 1 until reset.
- Byte extraction (finite sample, warm_done=1):
  - k = x1[7:0] ^ x2[12:5] ^ x3[17:10].
  - Denormals and zero are legal inputs.
- Pipeline:
  - Acceptance edge N registers k into stage 1.
  - Edge N+1 writes k into the FIFO.
  - key_valid is visible after edge N+1 if the FIFO was empty; there is no bypass path.
- FIFO:
  - First-word-fall-through: key_byte is the head entry whenever key_valid=1.
  - Pop occurs on an edge with key_valid & key_ready.
  - key_byte holds stable while key_valid=1 and key_ready=0.
- Full FIFO:
  - A push while full with no simultaneous pop drops the byte and sets overflow_err. FIFO contents are unchanged.
  - Push and pop on the same edge while full: both occur, level stays FIFO_DEPTH, no overflow.
- Empty FIFO:
  - A pop request is ignored (key_valid=0).
  - A push while empty gives level 1 on the next edge.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. fifo_level = write count − read count, range 0..FIFO_DEPTH.
- err_clr:
  - Clears both sticky flags on the next edge.
  - If a new error event occurs on the same edge, the set wins.
- enable=0: acceptance stops. The pipeline still drains and FIFO pops continue.

Decomposition:
- chaos_pkg holds:
  - typedef float32_t, a packed struct {sign, exp[7:0], mant[22:0]};
  - localparams EXP_NONFINITE=8'hFF, KEY_X1_LSB=0, KEY_X2_LSB=5, KEY_X3_LSB=10;
  - function is_nonfinite(float32_t).
- One sub-module, chaos_key_fifo: parameterised FWFT FIFO with push/pop/full/empty/level and drop-on-full reporting.
- Warm-up, classification and extraction stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 with random inputs → key_valid=0, fifo_level=0, warm_done=0, both error flags 0. Release, then assert rst_n=0 between edges → outputs clear without waiting for a clock edge.
2. Warm-up and extraction, WARMUP=4:
   - Feed 4 finite samples → no bytes, warm_done=1 after the 4th.
   - Feed x1=0x3DCCCCCD, x2=0x3C23D70A, x3=0x00000000 → key_byte=0x75, key_valid high two edges after acceptance.
3. Non-finite: during warm-up, feed x1=0x7FC00000 → nonfinite_err=1, warm-up count unchanged (warm_done still needs 4 finite samples), no byte produced. Pulse err_clr → flag 0.
4. Overflow, FIFO_DEPTH=4, key_ready=0:
   - Push 6 bytes → fifo_level=4, overflow_err=1 from the 5th push.
   - Drain → the first 4 bytes emerge in order.
5. Full with simultaneous pop: FIFO full, key_ready=1, continuous input → level stays 4, overflow_err stays 0, bytes stream in order.
6. Reset mid-stream: with fifo_level=3 and warm_done=1, pulse rst_n low → level 0, warm_done 0. After release, WARMUP samples are discarded again before the next byte.
